// File: rtl/booth_mult_sched.sv
// Two-requester round-robin front end for a serial-load Booth multiplier.
// It streams 0, A, B onto m_data, waits out the multiplier latency, then returns the product with its owner's id.
module booth_mult_sched #(
    parameter int WIDTH   = 16,
    parameter int LATENCY = 18
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 req0,
    input  logic [WIDTH-1:0]     a0,
    input  logic [WIDTH-1:0]     b0,
    input  logic                 req1,
    input  logic [WIDTH-1:0]     a1,
    input  logic [WIDTH-1:0]     b1,
    output logic                 gnt0,
    output logic                 gnt1,
    output logic                 res_valid,
    output logic [2*WIDTH-1:0]   res_data,
    output logic                 res_id,
    output logic                 busy,
    output logic                 m_start,
    output logic [WIDTH-1:0]     m_data,
    input  logic [2*WIDTH-1:0]   m_result
);

    localparam int CW = $clog2(LATENCY + 1);

    typedef enum logic [2:0] {
        S_IDLE, S_START, S_LOAD_A, S_LOAD_B, S_WAIT, S_DONE
    } state_t;

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   a_q, a_d, b_q, b_d;
    logic               own_q, own_d;
    logic               last_q, last_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [2*WIDTH-1:0] res_q, res_d;
    logic               rid_q, rid_d;
    logic               win;

    // Contention goes to whoever was not served last; a lone request always wins.
    assign win = (req0 && req1) ? ~last_q : req1;

    always_comb begin
        state_d   = state_q;
        a_d       = a_q;
        b_d       = b_q;
        own_d     = own_q;
        last_d    = last_q;
        cnt_d     = cnt_q;
        res_d     = res_q;
        rid_d     = rid_q;
        gnt0      = 1'b0;
        gnt1      = 1'b0;
        res_valid = 1'b0;
        res_data  = res_q;
        res_id    = rid_q;
        m_start   = 1'b0;
        m_data    = '0;
        busy      = (state_q != S_IDLE);
        case (state_q)
            S_IDLE: begin
                if (req0 || req1) begin
                    state_d = S_START;
                    own_d   = win;
                    last_d  = win;
                    a_d     = win ? a1 : a0;
                    b_d     = win ? b1 : b0;
                end
            end
            S_START: begin
                m_start = 1'b1;
                gnt0    = ~own_q;
                gnt1    = own_q;
                state_d = S_LOAD_A;
            end
            S_LOAD_A: begin
                m_start = 1'b1;
                m_data  = a_q;
                state_d = S_LOAD_B;
            end
            S_LOAD_B: begin
                m_start = 1'b1;
                m_data  = b_q;
                cnt_d   = CW'(LATENCY - 1);
                state_d = S_WAIT;
            end
            S_WAIT: begin
                m_start = 1'b1;
                if (cnt_q == '0) state_d = S_DONE;
                else             cnt_d   = cnt_q - 1'b1;
            end
            S_DONE: begin
                // Product is passed straight through this cycle and held afterwards.
                res_valid = 1'b1;
                res_data  = m_result;
                res_id    = own_q;
                res_d     = m_result;
                rid_d     = own_q;
                state_d   = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            a_q     <= '0;
            b_q     <= '0;
            own_q   <= 1'b0;
            last_q  <= 1'b1;
            cnt_q   <= '0;
            res_q   <= '0;
            rid_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            own_q   <= own_d;
            last_q  <= last_d;
            cnt_q   <= cnt_d;
            res_q   <= res_d;
            rid_q   <= rid_d;
        end
    end

endmodule

// File: tb/tb_booth_mult_sched.sv
// Directed bench for booth_mult_sched with a behavioural multiplier that captures A/B off the serial bus.
module tb_booth_mult_sched;

    localparam int W = 16;

    logic           clk = 1'b0;
    logic           rst, req0, req1;
    logic [W-1:0]   a0, b0, a1, b1;
    logic           gnt0, gnt1, res_valid, res_id, busy, m_start;
    logic [2*W-1:0] res_data, m_result;
    logic [W-1:0]   m_data;

    int ncmp = 0;
    int nfail = 0;

    booth_mult_sched #(.WIDTH(W), .LATENCY(18)) dut (
        .clk(clk), .rst(rst),
        .req0(req0), .a0(a0), .b0(b0),
        .req1(req1), .a1(a1), .b1(b1),
        .gnt0(gnt0), .gnt1(gnt1),
        .res_valid(res_valid), .res_data(res_data), .res_id(res_id),
        .busy(busy), .m_start(m_start), .m_data(m_data), .m_result(m_result)
    );

    always #5 clk = ~clk;

    // Multiplier model: second and third m_start cycles carry A and B.
    int           ph = 0;
    logic [W-1:0] cap_a = '0, cap_b = '0;
    always @(negedge clk) begin
        if (!m_start) ph <= 0;
        else begin
            if (ph == 1) cap_a <= m_data;
            if (ph == 2) cap_b <= m_data;
            if (ph < 3) ph <= ph + 1;
        end
    end
    assign m_result = 32'($signed(cap_a) * $signed(cap_b));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        ncmp++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_grant(input string tag, input logic g0, input logic g1);
        tick();
        chk({tag, "_gnt0"}, {31'b0, gnt0}, {31'b0, g0});
        chk({tag, "_gnt1"}, {31'b0, gnt1}, {31'b0, g1});
    endtask

    // Called in the START cycle (cycle 1); returns in the IDLE cycle after DONE.
    task automatic finish_op(input string tag, input logic id, input logic [W-1:0] ea,
                             input logic [W-1:0] eb, input logic [31:0] prod);
        int  cyc = 1;
        bit  seen = 0;
        int  bad_busy = 0;
        int  bad_gnt = 0;
        chk({tag, "_mdata_start"}, {16'b0, m_data}, 32'd0);
        chk({tag, "_mstart"}, {31'b0, m_start}, 32'd1);
        while (!seen && cyc < 40) begin
            tick();
            cyc++;
            if (cyc == 2) chk({tag, "_mdata_a"}, {16'b0, m_data}, {16'b0, ea});
            if (cyc == 3) chk({tag, "_mdata_b"}, {16'b0, m_data}, {16'b0, eb});
            if (res_valid) seen = 1;
            else begin
                if (!busy || !m_start) bad_busy++;
                if (gnt0 || gnt1) bad_gnt++;
            end
        end
        chk({tag, "_latency"}, cyc, 32'd22);
        chk({tag, "_data"}, res_data, prod);
        chk({tag, "_id"}, {31'b0, res_id}, {31'b0, id});
        chk({tag, "_done_mstart"}, {31'b0, m_start}, 32'd0);
        chk({tag, "_busy_during"}, bad_busy, 32'd0);
        chk({tag, "_no_gnt_during"}, bad_gnt, 32'd0);
        tick();
        chk({tag, "_valid_drop"}, {31'b0, res_valid}, 32'd0);
        chk({tag, "_data_hold"}, res_data, prod);
        chk({tag, "_idle_busy"}, {31'b0, busy}, 32'd0);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        chk("rst_outs", {26'b0, gnt0, gnt1, res_valid, res_id, busy, m_start}, 32'd0);
        chk("rst_res_data", res_data, 32'd0);
        chk("rst_m_data", {16'b0, m_data}, 32'd0);
        tick();
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1; req0 = 0; req1 = 0; a0 = '0; b0 = '0; a1 = '0; b1 = '0;
        do_reset();

        // Single request 10*13
        req0 = 1; a0 = 16'd10; b0 = 16'd13;
        expect_grant("t1", 1'b1, 1'b0);
        req0 = 0;
        finish_op("t1", 1'b0, 16'd10, 16'd13, 32'd130);

        // Simultaneous requests out of reset: req0 first, then req1 (-3*7)
        do_reset();
        req0 = 1; a0 = 16'd5; b0 = 16'd6;
        req1 = 1; a1 = 16'hFFFD; b1 = 16'd7;
        expect_grant("t2a", 1'b1, 1'b0);
        req0 = 0;
        finish_op("t2a", 1'b0, 16'd5, 16'd6, 32'd30);
        expect_grant("t2b", 1'b0, 1'b1);
        req1 = 0;
        finish_op("t2b", 1'b1, 16'hFFFD, 16'd7, 32'hFFFF_FFEB);

        // Both held high: strict alternation
        do_reset();
        req0 = 1; a0 = 16'd2; b0 = 16'd3;
        req1 = 1; a1 = 16'hFFFC; b1 = 16'hFFFB;
        for (int i = 0; i < 4; i++) begin
            if (i % 2 == 0) begin
                expect_grant("t3_0", 1'b1, 1'b0);
                finish_op("t3_0", 1'b0, 16'd2, 16'd3, 32'd6);
            end else begin
                expect_grant("t3_1", 1'b0, 1'b1);
                finish_op("t3_1", 1'b1, 16'hFFFC, 16'hFFFB, 32'd20);
            end
        end
        req0 = 0; req1 = 0;
        tick();

        // One-cycle pulse on req1, operands scrambled after grant
        req1 = 1; a1 = 16'd100; b1 = 16'hFFFE;
        expect_grant("t4", 1'b0, 1'b1);
        req1 = 0; a1 = 16'd7; b1 = 16'd7;
        finish_op("t4", 1'b1, 16'd100, 16'hFFFE, 32'hFFFF_FF38);

        // Reset during WAIT aborts the operation
        req0 = 1; a0 = 16'd9; b0 = 16'd9;
        expect_grant("t5", 1'b1, 1'b0);
        req0 = 0;
        for (int i = 0; i < 8; i++) tick();
        chk("t5_in_wait", {31'b0, m_start}, 32'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("t5_rst_outs", {26'b0, gnt0, gnt1, res_valid, res_id, busy, m_start}, 32'd0);
        chk("t5_rst_data", {res_data[15:0], m_data}, 32'd0);
        begin
            int stray = 0;
            for (int i = 0; i < 30; i++) begin
                tick();
                if (res_valid || busy) stray++;
            end
            chk("t5_no_valid", stray, 32'd0);
        end
        req0 = 1; a0 = 16'hFFFF; b0 = 16'hFFFF;
        expect_grant("t5b", 1'b1, 1'b0);
        req0 = 0;
        finish_op("t5b", 1'b0, 16'hFFFF, 16'hFFFF, 32'd1);

        // req1 arrives mid-operation; waits for the IDLE after DONE
        req0 = 1; a0 = 16'd300; b0 = 16'd200;
        expect_grant("t6a", 1'b1, 1'b0);
        req0 = 0;
        a1 = 16'h8000; b1 = 16'h8000;
        fork
            begin tick(); tick(); tick(); tick(); req1 = 1; end
        join_none
        finish_op("t6a", 1'b0, 16'd300, 16'd200, 32'h0000_EA60);
        chk("t6_idle_gnt1", {31'b0, gnt1}, 32'd0);
        expect_grant("t6b", 1'b0, 1'b1);
        req1 = 0;
        finish_op("t6b", 1'b1, 16'h8000, 16'h8000, 32'h4000_0000);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
